// File: rtl/uart_transmitter.sv
// UART transmit path: one-byte holding buffer feeding an LSB-first shift register,
// with bit timing taken from a shared free-running 16-phase baud counter.
module uart_transmitter #(
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] cnt,
  input  logic       wrn,
  input  logic [7:0] d_in,
  output logic       txd,
  output logic       t_empty,
  output logic       busy,
  output logic       overrun
);
  // state | meaning
  // IDLE  | line high, waiting for a byte in the holding buffer
  // START | start bit (0) on txd
  // DATA  | data bits d[0]..d[7] on txd, LSB first
  // STOP  | STOP_BITS stop bits (1) on txd
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  state_t     state;
  logic [7:0] hold_q;
  logic [7:0] shift_q;
  logic [2:0] bit_idx;
  logic       stop_idx;
  logic       bit_end;
  logic       wr;
  logic       load;

  assign bit_end = (cnt == 4'd15);
  assign wr      = ~wrn;

  // A new frame starts from IDLE or straight out of the last stop bit, so
  // back-to-back bytes leave no idle gap. Decided on the pre-edge t_empty.
  assign load = bit_end && !t_empty &&
                ((state == IDLE) || ((state == STOP) && (stop_idx == LAST_STOP)));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      hold_q   <= 8'h00;
      shift_q  <= 8'h00;
      bit_idx  <= 3'd0;
      stop_idx <= 1'b0;
      txd      <= 1'b1;
      t_empty  <= 1'b1;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (wr) begin
        if (t_empty) begin
          hold_q  <= d_in;
          t_empty <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end

      if (load) begin
        shift_q <= hold_q;
        t_empty <= 1'b1;
        txd     <= 1'b0;
        busy    <= 1'b1;
        state   <= START;
      end else if (bit_end) begin
        case (state)
          IDLE: begin
            txd <= 1'b1;
          end
          START: begin
            txd     <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            bit_idx <= 3'd0;
            state   <= DATA;
          end
          DATA: begin
            if (bit_idx != 3'd7) begin
              txd     <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end else begin
              txd      <= 1'b1;
              stop_idx <= 1'b0;
              state    <= STOP;
            end
          end
          STOP: begin
            if (stop_idx != LAST_STOP) begin
              stop_idx <= stop_idx + 1'b1;
            end else begin
              txd   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: begin
            txd   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a line monitor decodes frames off txd into a queue,
// and each scenario task compares them against the bytes it expects to see.
module tb_uart_transmitter;
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] cnt = 4'd0;
  logic       wrn = 1'b1;
  logic [7:0] d_in = 8'h00;
  logic       txd1, t_empty1, busy1, overrun1;
  logic       txd2, t_empty2, busy2, overrun2;
  logic       sel = 1'b0;
  logic       txd_mon;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  typedef struct {
    logic [7:0] data;
    int         s_cyc;
    int         s_ph;
    logic       start_ok;
    logic       stop_ok;
  } frame_t;

  frame_t     rx_q[$];
  logic [7:0] exp_q[$];

  uart_transmitter #(.STOP_BITS(1)) dut1 (
    .clk(clk), .clr(clr), .cnt(cnt), .wrn(wrn), .d_in(d_in),
    .txd(txd1), .t_empty(t_empty1), .busy(busy1), .overrun(overrun1)
  );

  uart_transmitter #(.STOP_BITS(2)) dut2 (
    .clk(clk), .clr(clr), .cnt(cnt), .wrn(wrn), .d_in(d_in),
    .txd(txd2), .t_empty(t_empty2), .busy(busy2), .overrun(overrun2)
  );

  assign txd_mon = sel ? txd2 : txd1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cnt <= cnt + 4'd1;
    cyc <= cyc + 1;
  end

  // Line monitor: samples each bit at its middle (8 cycles into the bit).
  always begin
    @(negedge clk);
    if (!clr && txd_mon === 1'b0) begin
      frame_t     f;
      bit         aborted;
      logic [2:0] bi;
      f.data = 8'h00; f.s_cyc = cyc; f.s_ph = int'(cnt);
      f.start_ok = 1'b0; f.stop_ok = 1'b0; aborted = 1'b0;
      for (int k = 1; k <= 152; k++) begin
        @(negedge clk);
        if (clr) begin
          aborted = 1'b1;
          break;
        end
        if (k == 8) f.start_ok = (txd_mon === 1'b0);
        else if (k == 152) f.stop_ok = (txd_mon === 1'b1);
        else if (k > 8 && ((k - 8) % 16) == 0) begin
          bi = 3'((k - 8) / 16 - 1);
          f.data[bi] = txd_mon;
        end
      end
      if (!aborted) rx_q.push_back(f);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic [3:0] ph);
    @(negedge clk);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    while (cnt != ph) @(negedge clk);
    clr = 1'b0;
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic write_at(input logic [3:0] ph, input logic [7:0] b, output int w);
    @(negedge clk);
    while (cnt != ph) @(negedge clk);
    wrn = 1'b0; d_in = b;
    @(negedge clk);
    wrn = 1'b1;
    w = cyc;
  endtask

  task automatic wait_start(output int s);
    int n;
    n = 0; s = -1000;
    @(negedge clk);
    while (txd_mon !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (txd_mon !== 1'b0) begin
      n_fail++;
      $display("FAIL start_timeout: txd=%b expected 0", txd_mon);
    end else s = cyc;
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (rx_q.size() < n && t < 200 * n + 200) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (rx_q.size() < n) begin
      n_fail++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", rx_q.size(), n);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    clr = 1'b1;
    #1;
    n_tests += 4;
    if (txd1 !== 1'b1)     begin n_fail++; $display("FAIL reset_txd: got %b expected 1", txd1); end
    if (t_empty1 !== 1'b1) begin n_fail++; $display("FAIL reset_t_empty: got %b expected 1", t_empty1); end
    if (busy1 !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    if (overrun1 !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun1); end
    do_reset(4'd7);
  endtask

  task automatic test_single;
    int w, s;
    frame_t f;
    logic [7:0] e;
    write_at(4'd3, 8'hA5, w);
    exp_q.push_back(8'hA5);
    n_tests++;
    if (t_empty1 !== 1'b0) begin n_fail++; $display("FAIL single_t_empty_after_write: got %b expected 0", t_empty1); end
    wait_start(s);
    n_tests += 3;
    if (s - w != 12)       begin n_fail++; $display("FAIL single_latency: got %0d expected 12", s - w); end
    if (t_empty1 !== 1'b1) begin n_fail++; $display("FAIL single_t_empty_at_start: got %b expected 1", t_empty1); end
    if (busy1 !== 1'b1)    begin n_fail++; $display("FAIL single_busy_at_start: got %b expected 1", busy1); end
    wait_frames(1);
    f = rx_q.pop_front();
    e = exp_q.pop_front();
    n_tests += 4;
    if (f.data !== e)      begin n_fail++; $display("FAIL single_data: got %h expected %h", f.data, e); end
    if (f.s_ph != 0)       begin n_fail++; $display("FAIL single_phase: got %0d expected 0", f.s_ph); end
    if (!f.start_ok)       begin n_fail++; $display("FAIL single_start_bit: got 1 expected 0"); end
    if (!f.stop_ok)        begin n_fail++; $display("FAIL single_stop_bit: got 0 expected 1"); end
    wait_cyc(s + 159);
    n_tests++;
    if (busy1 !== 1'b1)    begin n_fail++; $display("FAIL single_busy_last_stop: got %b expected 1", busy1); end
    @(negedge clk);
    n_tests += 2;
    if (busy1 !== 1'b0)    begin n_fail++; $display("FAIL single_busy_after_stop: got %b expected 0", busy1); end
    if (txd1 !== 1'b1)     begin n_fail++; $display("FAIL single_idle_txd: got %b expected 1", txd1); end
  endtask

  task automatic test_back_to_back;
    int w, s;
    frame_t f0, f1;
    logic [7:0] e0, e1;
    do_reset(4'd11);
    write_at(4'd7, 8'h55, w);
    exp_q.push_back(8'h55);
    wait_start(s);
    repeat (40) @(negedge clk);
    write_at(4'd5, 8'hC3, w);
    exp_q.push_back(8'hC3);
    wait_frames(2);
    f0 = rx_q.pop_front(); f1 = rx_q.pop_front();
    e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
    n_tests += 4;
    if (f0.data !== e0) begin n_fail++; $display("FAIL b2b_data0: got %h expected %h", f0.data, e0); end
    if (f1.data !== e1) begin n_fail++; $display("FAIL b2b_data1: got %h expected %h", f1.data, e1); end
    if (f1.s_cyc - f0.s_cyc != 160) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 160", f1.s_cyc - f0.s_cyc); end
    if (overrun1 !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b expected 0", overrun1); end
  endtask

  task automatic test_overrun;
    int w, s;
    frame_t f0, f1;
    logic [7:0] e0, e1;
    do_reset(4'd0);
    write_at(4'd2, 8'h01, w);
    exp_q.push_back(8'h01);
    wait_start(s);
    write_at(4'd4, 8'h02, w);
    exp_q.push_back(8'h02);
    n_tests++;
    if (overrun1 !== 1'b0) begin n_fail++; $display("FAIL ovr_before: got %b expected 0", overrun1); end
    write_at(4'd9, 8'h03, w);
    n_tests++;
    if (overrun1 !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun1); end
    wait_frames(2);
    f0 = rx_q.pop_front(); f1 = rx_q.pop_front();
    e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
    n_tests += 2;
    if (f0.data !== e0) begin n_fail++; $display("FAIL ovr_data0: got %h expected %h", f0.data, e0); end
    if (f1.data !== e1) begin n_fail++; $display("FAIL ovr_data1: got %h expected %h", f1.data, e1); end
    repeat (200) @(negedge clk);
    n_tests += 2;
    if (rx_q.size() != 0)  begin n_fail++; $display("FAIL ovr_dropped: got %0d extra frames expected 0", rx_q.size()); end
    if (overrun1 !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", overrun1); end
  endtask

  task automatic test_same_edge;
    int w, s;
    frame_t f0, f1;
    do_reset(4'd13);
    write_at(4'd2, 8'h11, w);
    wait_start(s);
    write_at(4'd6, 8'h22, w);
    wait_cyc(s + 159);
    n_tests++;
    if (overrun1 !== 1'b0) begin n_fail++; $display("FAIL same_edge_pre_overrun: got %b expected 0", overrun1); end
    wrn = 1'b0; d_in = 8'h33;
    @(negedge clk);
    wrn = 1'b1;
    n_tests += 3;
    if (overrun1 !== 1'b1) begin n_fail++; $display("FAIL same_edge_overrun: got %b expected 1", overrun1); end
    if (t_empty1 !== 1'b1) begin n_fail++; $display("FAIL same_edge_t_empty: got %b expected 1", t_empty1); end
    if (txd1 !== 1'b0)     begin n_fail++; $display("FAIL same_edge_no_gap: got %b expected 0", txd1); end
    wait_frames(2);
    f0 = rx_q.pop_front(); f1 = rx_q.pop_front();
    n_tests += 2;
    if (f0.data !== 8'h11) begin n_fail++; $display("FAIL same_edge_data0: got %h expected 11", f0.data); end
    if (f1.data !== 8'h22) begin n_fail++; $display("FAIL same_edge_data1: got %h expected 22", f1.data); end
    repeat (200) @(negedge clk);
    n_tests++;
    if (rx_q.size() != 0)  begin n_fail++; $display("FAIL same_edge_dropped: got %0d extra frames expected 0", rx_q.size()); end
  endtask

  task automatic test_hold_low;
    frame_t f;
    do_reset(4'd9);
    @(negedge clk);
    while (cnt != 4'd2) @(negedge clk);
    wrn = 1'b0; d_in = 8'h3C;
    @(negedge clk);
    d_in = 8'hFF;
    n_tests += 2;
    if (t_empty1 !== 1'b0) begin n_fail++; $display("FAIL hold_t_empty: got %b expected 0", t_empty1); end
    if (overrun1 !== 1'b0) begin n_fail++; $display("FAIL hold_first_overrun: got %b expected 0", overrun1); end
    repeat (2) @(negedge clk);
    wrn = 1'b1;
    n_tests++;
    if (overrun1 !== 1'b1) begin n_fail++; $display("FAIL hold_overrun: got %b expected 1", overrun1); end
    wait_frames(1);
    f = rx_q.pop_front();
    n_tests++;
    if (f.data !== 8'h3C) begin n_fail++; $display("FAIL hold_data: got %h expected 3c", f.data); end
  endtask

  task automatic test_write_edges;
    int w, s;
    frame_t f;
    do_reset(4'd9);
    write_at(4'd15, 8'h96, w);
    n_tests += 2;
    if (t_empty1 !== 1'b0) begin n_fail++; $display("FAIL at15_t_empty: got %b expected 0", t_empty1); end
    if (txd1 !== 1'b1)     begin n_fail++; $display("FAIL at15_no_start: got %b expected 1", txd1); end
    wait_start(s);
    n_tests++;
    if (s - w != 16) begin n_fail++; $display("FAIL at15_latency: got %0d expected 16", s - w); end
    wait_frames(1);
    f = rx_q.pop_front();
    n_tests++;
    if (f.data !== 8'h96) begin n_fail++; $display("FAIL at15_data: got %h expected 96", f.data); end
    repeat (20) @(negedge clk);
    write_at(4'd14, 8'h81, w);
    wait_start(s);
    n_tests++;
    if (s - w != 1) begin n_fail++; $display("FAIL best_latency: got %0d expected 1", s - w); end
    wait_frames(1);
    f = rx_q.pop_front();
    n_tests++;
    if (f.data !== 8'h81) begin n_fail++; $display("FAIL best_data: got %h expected 81", f.data); end
  endtask

  task automatic test_clr_mid;
    int w, s;
    bit activity;
    do_reset(4'd4);
    write_at(4'd6, 8'h52, w);
    wait_start(s);
    wait_cyc(s + 16 * 4 + 8);
    n_tests++;
    if (txd1 !== 1'b0) begin n_fail++; $display("FAIL clr_mid_d3: got %b expected 0", txd1); end
    clr = 1'b1;
    #1;
    n_tests += 3;
    if (txd1 !== 1'b1)     begin n_fail++; $display("FAIL clr_mid_txd: got %b expected 1", txd1); end
    if (t_empty1 !== 1'b1) begin n_fail++; $display("FAIL clr_mid_t_empty: got %b expected 1", t_empty1); end
    if (busy1 !== 1'b0)    begin n_fail++; $display("FAIL clr_mid_busy: got %b expected 0", busy1); end
    repeat (3) @(negedge clk);
    clr = 1'b0;
    activity = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (txd1 !== 1'b1) activity = 1'b1;
    end
    n_tests += 2;
    if (activity)         begin n_fail++; $display("FAIL clr_mid_quiet: got activity expected none"); end
    if (rx_q.size() != 0) begin n_fail++; $display("FAIL clr_mid_frames: got %0d expected 0", rx_q.size()); end
  endtask

  task automatic test_two_stop;
    int w, s;
    frame_t f0, f1;
    logic [7:0] e0, e1;
    do_reset(4'd5);
    sel = 1'b1;
    write_at(4'd1, 8'hAA, w);
    exp_q.push_back(8'hAA);
    wait_start(s);
    repeat (30) @(negedge clk);
    write_at(4'd3, 8'h0F, w);
    exp_q.push_back(8'h0F);
    wait_frames(2);
    f0 = rx_q.pop_front(); f1 = rx_q.pop_front();
    e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
    n_tests += 4;
    if (f0.data !== e0) begin n_fail++; $display("FAIL two_stop_data0: got %h expected %h", f0.data, e0); end
    if (f1.data !== e1) begin n_fail++; $display("FAIL two_stop_data1: got %h expected %h", f1.data, e1); end
    if (f1.s_cyc - f0.s_cyc != 176) begin n_fail++; $display("FAIL two_stop_spacing: got %0d expected 176", f1.s_cyc - f0.s_cyc); end
    if (overrun2 !== 1'b0) begin n_fail++; $display("FAIL two_stop_overrun: got %b expected 0", overrun2); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_same_edge();
    test_hold_low();
    test_write_edges();
    test_clr_mid();
    test_two_stop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
